// File: rtl/ex_muldiv_unit.sv
// RV32M multi-cycle multiply/divide unit for the EX stage.
// Define EX_FAST_MUL_EN for a single-cycle multiplier path.
package ex_muldiv_pkg;
    typedef enum logic [1:0] {
        FW_NONE    = 2'b00,
        FW_MEM_ALU = 2'b01,
        FW_WB_DATA = 2'b10
    } fw_sel_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } md_state_e;
endpackage

module ex_muldiv_unit
    import ex_muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  EX_start_i,
    input  logic                  EX_flush_i,
    input  logic [2:0]            EX_funct3_i,
    input  logic [DATA_WIDTH-1:0] EX_rd_data1_i,
    input  logic [DATA_WIDTH-1:0] EX_rd_data2_i,
    input  logic [DATA_WIDTH-1:0] MEM_alu_result_i,
    input  logic [DATA_WIDTH-1:0] WB_wr_data_i,
    input  fw_sel_e               EX_forwardA_i,
    input  fw_sel_e               EX_forwardB_i,
    input  logic [TAG_WIDTH-1:0]  EX_rd_i,
    output logic                  EX_busy_o,
    output logic                  EX_done_o,
    output logic [DATA_WIDTH-1:0] EX_result_o,
    output logic [TAG_WIDTH-1:0]  EX_rd_o
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    md_state_e state_q, state_d;

    logic [2:0]           op_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic                 neg_a_q, neg_b_q, spec_q;
    logic [W-1:0]         b_mag_q;
    logic [W-1:0]         hi_q, lo_q;
    logic [CW-1:0]        cnt_q;
    logic [W-1:0]         res_q;
    logic [TAG_WIDTH-1:0] rd_q;

    logic [W-1:0] op_a, op_b;
    logic         is_div_in, sgn_a_in, sgn_b_in;
    logic         neg_a_in, neg_b_in;
    logic [W-1:0] a_mag_in, b_mag_in;
    logic         div_zero_in, div_ovf_in, special_in;
    logic [W-1:0] spec_quo_in, spec_rem_in;
    logic         accept, last_iter;

    always_comb begin
        op_a = EX_rd_data1_i;
        case (EX_forwardA_i)
            FW_MEM_ALU: op_a = MEM_alu_result_i;
            FW_WB_DATA: op_a = WB_wr_data_i;
            default:    op_a = EX_rd_data1_i;
        endcase
    end

    always_comb begin
        op_b = EX_rd_data2_i;
        case (EX_forwardB_i)
            FW_MEM_ALU: op_b = MEM_alu_result_i;
            FW_WB_DATA: op_b = WB_wr_data_i;
            default:    op_b = EX_rd_data2_i;
        endcase
    end

    // MULH, MULHSU, DIV, REM treat A as signed; MULH, DIV, REM treat B as signed
    assign is_div_in = EX_funct3_i[2];
    assign sgn_a_in  = (EX_funct3_i == 3'b001) || (EX_funct3_i == 3'b010)
                    || (EX_funct3_i == 3'b100) || (EX_funct3_i == 3'b110);
    assign sgn_b_in  = (EX_funct3_i == 3'b001) || (EX_funct3_i == 3'b100)
                    || (EX_funct3_i == 3'b110);
    assign neg_a_in  = sgn_a_in & op_a[W-1];
    assign neg_b_in  = sgn_b_in & op_b[W-1];
    assign a_mag_in  = neg_a_in ? -op_a : op_a;
    assign b_mag_in  = neg_b_in ? -op_b : op_b;

    assign div_zero_in = is_div_in && (op_b == '0);
    assign div_ovf_in  = is_div_in && sgn_b_in && (op_b == '1)
                      && (op_a == {1'b1, {(W-1){1'b0}}});
    assign special_in  = div_zero_in | div_ovf_in;
    assign spec_quo_in = div_zero_in ? '1 : op_a;
    assign spec_rem_in = div_zero_in ? op_a : '0;

    assign accept    = EX_start_i && !EX_flush_i
                    && (state_q == S_IDLE || state_q == S_DONE);
    assign last_iter = (cnt_q == CW'(W - 1));

`ifdef EX_FAST_MUL_EN
    logic                  fast_in;
    logic signed [W:0]     fast_a, fast_b;
    logic signed [2*W-1:0] fast_p;
    logic [W-1:0]          fast_res;

    assign fast_in  = !is_div_in;
    assign fast_a   = {neg_a_in, op_a};
    assign fast_b   = {neg_b_in, op_b};
    assign fast_p   = (2*W)'(fast_a * fast_b);
    assign fast_res = (EX_funct3_i == 3'b000) ? fast_p[W-1:0]
                                              : fast_p[2*W-1:W];
`endif

    always_comb begin
        state_d = state_q;
        if (EX_flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (EX_start_i) begin
`ifdef EX_FAST_MUL_EN
                        if (fast_in)
                            state_d = S_DONE;
                        else if (special_in)
                            state_d = S_FIX;
                        else
                            state_d = S_CALC;
`else
                        state_d = special_in ? S_FIX : S_CALC;
`endif
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CALC:  state_d = last_iter ? S_FIX : S_CALC;
                S_FIX:   state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // One iteration: shift-add for multiply, restoring step for divide
    logic [W:0]   mul_sum, div_sh, div_diff;
    logic [W-1:0] hi_n, lo_n;

    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_mag_q} : '0);
        div_sh   = {hi_q, lo_q[W-1]};
        div_diff = div_sh - {1'b0, b_mag_q};
        if (op_q[2]) begin
            if (!div_diff[W]) begin
                hi_n = div_diff[W-1:0];
                lo_n = {lo_q[W-2:0], 1'b1};
            end else begin
                hi_n = div_sh[W-1:0];
                lo_n = {lo_q[W-2:0], 1'b0};
            end
        end else begin
            hi_n = mul_sum[W:1];
            lo_n = {mul_sum[0], lo_q[W-1:1]};
        end
    end

    logic [2*W-1:0] prod, prod_fix;
    logic [W-1:0]   quo_fix, rem_fix, fix_res;
    logic           sgn_x;

    always_comb begin
        sgn_x    = neg_a_q ^ neg_b_q;
        prod     = {hi_q, lo_q};
        prod_fix = sgn_x ? -prod : prod;
        quo_fix  = (spec_q || !sgn_x) ? lo_q : -lo_q;
        rem_fix  = (spec_q || !neg_a_q) ? hi_q : -hi_q;
        case (op_q)
            3'b000:         fix_res = prod_fix[W-1:0];
            3'b001, 3'b010,
            3'b011:         fix_res = prod_fix[2*W-1:W];
            3'b100, 3'b101: fix_res = quo_fix;
            default:        fix_res = rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            tag_q   <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            spec_q  <= 1'b0;
            b_mag_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            rd_q    <= '0;
        end else if (accept) begin
            op_q    <= EX_funct3_i;
            tag_q   <= EX_rd_i;
            neg_a_q <= neg_a_in;
            neg_b_q <= neg_b_in;
            spec_q  <= special_in;
            b_mag_q <= b_mag_in;
            cnt_q   <= '0;
            hi_q    <= special_in ? spec_rem_in : '0;
            lo_q    <= special_in ? spec_quo_in : a_mag_in;
`ifdef EX_FAST_MUL_EN
            if (fast_in) begin
                res_q <= fast_res;
                rd_q  <= EX_rd_i;
            end
`endif
        end else if (!EX_flush_i && state_q == S_CALC) begin
            cnt_q <= cnt_q + 1'b1;
            hi_q  <= hi_n;
            lo_q  <= lo_n;
        end else if (!EX_flush_i && state_q == S_FIX) begin
            res_q <= fix_res;
            rd_q  <= tag_q;
        end
    end

    assign EX_busy_o   = (state_q == S_CALC) || (state_q == S_FIX);
    assign EX_done_o   = (state_q == S_DONE);
    assign EX_result_o = res_q;
    assign EX_rd_o     = rd_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit (DATA_WIDTH=32).
// Directed plan ops plus randomized ops against an arithmetic model.
module tb_ex_muldiv_unit;
    import ex_muldiv_pkg::*;

`ifdef EX_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rd1 = '0, rd2 = '0, mem = '0, wb = '0;
    fw_sel_e     fwa = FW_NONE, fwb = FW_NONE;
    logic [4:0]  rd_tag = '0;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int failures = 0;

    ex_muldiv_unit #(.DATA_WIDTH(32), .TAG_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .EX_start_i(start), .EX_flush_i(flush),
        .EX_funct3_i(funct3),
        .EX_rd_data1_i(rd1), .EX_rd_data2_i(rd2),
        .MEM_alu_result_i(mem), .WB_wr_data_i(wb),
        .EX_forwardA_i(fwa), .EX_forwardB_i(fwb),
        .EX_rd_i(rd_tag),
        .EX_busy_o(busy), .EX_done_o(done),
        .EX_result_o(result), .EX_rd_o(rd_out)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(logic [2:0] f, logic [31:0] a,
                                          logic [31:0] b);
        longint sa, sb;
        logic [63:0] p;
        int ia, ib;
        logic ovf;
        ia = a;
        ib = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin sa = ia; sb = ib; p = sa * sb; return p[63:32]; end
            3'd2: begin sa = ia; sb = {32'd0, b}; p = sa * sb; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(logic [2:0] f, logic [31:0] a,
                                      logic [31:0] b);
        if (!f[2]) return 1'b0;
        if (b == 0) return 1'b1;
        return !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    function automatic int exp_lat(logic [2:0] f, logic [31:0] a,
                                   logic [31:0] b);
        if (!f[2] && FAST) return 1;
        if (is_special(f, a, b)) return 2;
        return 34;
    endfunction

    function automatic logic [31:0] pick(fw_sel_e s, logic [31:0] r,
                                         logic [31:0] m, logic [31:0] w);
        if (s == FW_MEM_ALU) return m;
        if (s == FW_WB_DATA) return w;
        return r;
    endfunction

    task automatic issue(logic [2:0] f, logic [31:0] r1, logic [31:0] r2,
                         logic [31:0] m, logic [31:0] w, fw_sel_e fa,
                         fw_sel_e fb, logic [4:0] tag);
        funct3 = f; rd1 = r1; rd2 = r2; mem = m; wb = w;
        fwa = fa; fwb = fb; rd_tag = tag;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bc);
        lat = -1;
        bc = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (busy) bc++;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_op(string name, logic [2:0] f, logic [31:0] r1,
                          logic [31:0] r2, logic [31:0] m, logic [31:0] w,
                          fw_sel_e fa, fw_sel_e fb, logic [4:0] tag);
        int lat, bc, el;
        logic [31:0] a, b;
        a = pick(fa, r1, m, w);
        b = pick(fb, r2, m, w);
        el = exp_lat(f, a, b);
        issue(f, r1, r2, m, w, fa, fb, tag);
        wait_done(lat, bc);
        chk({name, "_lat"}, 64'(lat), 64'(el));
        chk({name, "_busy"}, 64'(bc), 64'(el - 1));
        chk({name, "_res"}, 64'(result), 64'(model(f, a, b)));
        chk({name, "_rd"}, 64'(rd_out), 64'(tag));
        @(negedge clk);
        chk({name, "_pulse"}, 64'(done), 64'(0));
    endtask

    initial begin
        int lat, bc, cnt_b, cnt_d;
        logic [2:0] f;
        logic [31:0] a, b;

        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_res", 64'(result), 64'(0));
        chk("rst_rd", 64'(rd_out), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'(0));

        run_op("mul", 3'd0, 7, 32'hFFFF_FFFD, 0, 0, FW_NONE, FW_NONE, 5);
        chk("mul_plan", 64'(result), 64'h0000_0000_FFFF_FFEB);
        run_op("mulhu", 3'd3, '1, '1, 0, 0, FW_NONE, FW_NONE, 1);
        chk("mulhu_plan", 64'(result), 64'h0000_0000_FFFF_FFFE);
        run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 0, 0,
               FW_NONE, FW_NONE, 2);
        chk("mulh_plan", 64'(result), 64'h0000_0000_4000_0000);
        run_op("mulhsu", 3'd2, '1, 2, 0, 0, FW_NONE, FW_NONE, 3);
        chk("mulhsu_plan", 64'(result), 64'h0000_0000_FFFF_FFFF);
        run_op("div", 3'd4, 32'hFFFF_FFF9, 2, 0, 0, FW_NONE, FW_NONE, 4);
        chk("div_plan", 64'(result), 64'h0000_0000_FFFF_FFFD);
        run_op("rem", 3'd6, 32'hFFFF_FFF9, 2, 0, 0, FW_NONE, FW_NONE, 6);
        chk("rem_plan", 64'(result), 64'h0000_0000_FFFF_FFFF);
        run_op("remu", 3'd7, 100, 7, 0, 0, FW_NONE, FW_NONE, 8);
        chk("remu_plan", 64'(result), 64'd2);
        run_op("divu0", 3'd5, 5, 0, 0, 0, FW_NONE, FW_NONE, 9);
        chk("divu0_plan", 64'(result), 64'h0000_0000_FFFF_FFFF);
        run_op("rem0", 3'd6, 5, 0, 0, 0, FW_NONE, FW_NONE, 10);
        chk("rem0_plan", 64'(result), 64'd5);
        run_op("divovf", 3'd4, 32'h8000_0000, '1, 0, 0, FW_NONE, FW_NONE, 11);
        chk("divovf_plan", 64'(result), 64'h0000_0000_8000_0000);
        run_op("removf", 3'd6, 32'h8000_0000, '1, 0, 0, FW_NONE, FW_NONE, 12);
        chk("removf_plan", 64'(result), 64'd0);
        run_op("fwd", 3'd5, 10, 3, 99, 9, FW_MEM_ALU, FW_WB_DATA, 13);
        chk("fwd_plan", 64'(result), 64'd11);
        run_op("divu", 3'd5, 100, 7, 0, 0, FW_NONE, FW_NONE, 7);
        chk("divu_plan", 64'(result), 64'd14);

        // Flush a DIV in its cycle 10
        issue(3'd4, 1000, 3, 0, 0, FW_NONE, FW_NONE, 20);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", 64'(busy), 64'(0));
        chk("flush_done", 64'(done), 64'(0));
        chk("flush_res", 64'(result), 64'd14);
        chk("flush_rd", 64'(rd_out), 64'd7);
        cnt_d = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) cnt_d++;
        end
        chk("flush_nodone", 64'(cnt_d), 64'(0));

        // Start together with flush is dropped
        flush = 1'b1;
        issue(3'd5, 50, 5, 0, 0, FW_NONE, FW_NONE, 21);
        flush = 1'b0;
        cnt_b = 0;
        cnt_d = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy) cnt_b++;
            if (done) cnt_d++;
        end
        chk("drop_busy", 64'(cnt_b), 64'(0));
        chk("drop_done", 64'(cnt_d), 64'(0));
        chk("drop_res", 64'(result), 64'd14);

        // Back-to-back: start in DONE cycle
        issue(3'd5, 100, 7, 0, 0, FW_NONE, FW_NONE, 1);
        wait_done(lat, bc);
        chk("b2b1_res", 64'(result), 64'd14);
        issue(3'd7, 100, 7, 0, 0, FW_NONE, FW_NONE, 2);
        wait_done(lat, bc);
        chk("b2b2_lat", 64'(lat), 64'd34);
        chk("b2b2_busy", 64'(bc), 64'd33);
        chk("b2b2_res", 64'(result), 64'd2);
        chk("b2b2_rd", 64'(rd_out), 64'd2);
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 0;
                1: begin a = 32'h8000_0000; b = '1; end
                2: b = 32'($urandom_range(1, 20));
                3: a = 32'($urandom_range(0, 1000));
                default: ;
            endcase
            run_op("rand", f, a, b, $urandom, $urandom,
                   fw_sel_e'($urandom_range(0, 2)), FW_NONE, 5'($urandom));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        // Asynchronous reset mid-operation
        issue(3'd5, 77, 3, 0, 0, FW_NONE, FW_NONE, 9);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("amid_busy", 64'(busy), 64'(0));
        chk("amid_done", 64'(done), 64'(0));
        chk("amid_res", 64'(result), 64'(0));
        chk("amid_rd", 64'(rd_out), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("amid_idle", 64'(busy), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Multi-cycle RV32M multiply/divide unit in the EX stage, beside the single-cycle ALU. It captures forwarded operands on a start request and holds the pipeline with `EX_busy_o` while it computes. It then returns the result and destination tag with a one-cycle done pulse. The unit is parametrised in data width; an optional single-cycle multiplier path is available.

## Interface
Parameters:
- `DATA_WIDTH`, 32: operand/result width; must be even and ≥ 8.
- `TAG_WIDTH`, 5: destination register tag width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `EX_start_i`  in  1  start request; accepted only in IDLE or DONE.
- `EX_flush_i`  in  1  abort; has priority over everything except reset.
- `EX_funct3_i`  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `EX_rd_data1_i`, `EX_rd_data2_i`  in  DATA_WIDTH  register-file operands.
- `MEM_alu_result_i`, `WB_wr_data_i`  in  DATA_WIDTH  forwarding sources.
- `EX_forwardA_i`, `EX_forwardB_i`  in  fw_sel_e  operand select: FW_NONE, FW_MEM_ALU or FW_WB_DATA.
- `EX_rd_i`  in  TAG_WIDTH  destination tag.
- `EX_busy_o`  out  1  high in CALC/FIX; the pipeline stalls on it.
- `EX_done_o`  out  1  one-cycle result-valid pulse.
- `EX_result_o`  out  DATA_WIDTH  result; held until the next accepted start.
- `EX_rd_o`  out  TAG_WIDTH  tag of the completed op; held with the result.

## Operation
- Operand A is taken from rd_data1, MEM or WB according to forwardA; B likewise from forwardB. Any other fw_sel_e encoding selects rd_data.
- Operands, funct3 and tag are latched on the edge where start is accepted.
- States and transitions:
  - IDLE: go to CALC on start.
  - CALC: iterate; go to FIX after the last iteration.
  - FIX: sign correction and high/low select; go to DONE.
  - DONE: `EX_done_o`=1; go to CALC on a new start, else IDLE.
- Multiply: radix-2 shift-add on 2·DATA_WIDTH-bit magnitudes, one bit per cycle, DATA_WIDTH iterations.
  - Signedness: MULH is signed×signed, MULHSU is signed×unsigned, MULHU and MUL are unsigned.
  - The FIX state negates the product if the operand signs differ (signed operands only).
  - MUL returns the low half; MULH* return the high half.
- Divide: restoring divide on magnitudes, DATA_WIDTH iterations.
  - FIX negates the quotient if the signs differ and gives the remainder the dividend's sign.
- Special cases skip CALC (IDLE/DONE→FIX directly):
  - Divide by zero: quotient = all ones; remainder = dividend (both signed and unsigned).
  - Signed overflow (B = −1 and A = most-negative): quotient = A; remainder = 0.
- Start while in CALC/FIX: ignored.
- Flush: next state IDLE, no done pulse, result/tag registers unchanged. Flush together with start: flush wins and the start is dropped.

## Timing
- Reset values: state IDLE; `EX_busy_o`=0, `EX_done_o`=0, `EX_result_o`=0, `EX_rd_o`=0.
- Start accepted in cycle 0.
  - Normal op: CALC in cycles 1..DATA_WIDTH, FIX in cycle DATA_WIDTH+1, done in cycle DATA_WIDTH+2 (34 for DATA_WIDTH=32).
  - Special-case divide: FIX in cycle 1, done in cycle 2.
- `EX_result_o`/`EX_rd_o` change only in the cycle done rises and are stable while done is high.
- Back-to-back ops: a start in a DONE cycle is accepted, so there are no idle bubbles between ops.
- `EX_busy_o` is registered (decoded from the state register); it is never combinationally dependent on start.
- Reset asserted mid-operation: immediately IDLE and all outputs 0.

## Configuration
- `EX_FAST_MUL_EN` defined: MUL/MULH/MULHSU/MULHU use a single-cycle signed (DATA_WIDTH+1)×(DATA_WIDTH+1) multiply.
  - The op goes straight from start to DONE: done in cycle 1, `EX_busy_o` never asserts.
  - Divide behaviour is unchanged.
- Undefined: iterative multiply as described under Operation (done in cycle DATA_WIDTH+2).

## Test plan
- MUL A=7, B=0xFFFFFFFD, tag 5, FW_NONE → done in cycle 34 (cycle 1 with EX_FAST_MUL_EN), result 0xFFFFFFEB, `EX_rd_o`=5, busy high cycles 1–33.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULH 0x80000000×0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD. REM of the same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF and REM 5/0 → 5, each done in cycle 2. DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM of the same → 0, each done in cycle 2.
- Forwarding: rd_data1=10, MEM=99, forwardA=FW_MEM_ALU, rd_data2=3, WB=9, forwardB=FW_WB_DATA, DIVU → 11.
- Flush in cycle 10 of a DIV → no done pulse, IDLE in cycle 11, previous result held. A start issued together with a flush is dropped. A start issued in a DONE cycle is accepted, with no bubble.
